// File: rtl/button_index_encoder_pkg.sv
// Shared types, default timing constants and bit-vector helpers for the button index encoder.
package button_index_encoder_pkg;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} btn_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int REPEAT_CYCLES_DEF   = 50_000_000;

  // Position of the lowest set bit; 0 when nothing is set.
  function automatic int onehot_to_idx(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic popcount_gt1(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/button_index_encoder_debounce_bit.sv
// One button bit: 2-flop synchroniser followed by a consecutive-disagreement debounce counter.
module debounce_bit
  import button_index_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic q_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      cnt      <= '0;
      q_stable <= 1'b0;
    end else begin
      sync_p0 <= d_raw;
      sync_p1 <= sync_p0;
      // The flip happens on the last disagreeing cycle, so cnt stops at CNT_LAST and never wraps.
      if (sync_p1 == q_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        q_stable <= sync_p1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_index_encoder.sv
// Debounced pushbuttons -> binary index with valid/multi strobes.
// Optional auto-repeat of a held single button is enabled by defining BUTTON_ENCODER_REPEAT_EN.
module button_index_encoder
  import button_index_encoder_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
`ifdef BUTTON_ENCODER_REPEAT_EN
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
`endif
  localparam int IDX_W          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             multi,
  output logic             held
);

  logic [N_BTN-1:0] stable;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .d_raw   (btn_raw[g]),
      .q_stable(stable[g])
    );
  end

  logic any_btn;
  logic chord;
  logic single;

  always_comb begin
    any_btn = |stable;
    chord   = popcount_gt1(32'(stable));
    single  = any_btn && !chord;
  end

  btn_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic             multi_d;

`ifdef BUTTON_ENCODER_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [N_BTN-1:0] stable_prev;
  logic [REP_W-1:0] rep_cnt, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    valid_d = 1'b0;
    multi_d = 1'b0;
`ifdef BUTTON_ENCODER_REPEAT_EN
    rep_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_btn) begin
          state_d = HELD;
          if (chord) begin
            multi_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            idx_d   = IDX_W'(onehot_to_idx(32'(stable)));
          end
        end
      end
      HELD: begin
        if (!any_btn) begin
          state_d = IDLE;
        end
`ifdef BUTTON_ENCODER_REPEAT_EN
        // Repeat only a steady single press; any change of the vector restarts the period.
        else if (single && (stable == stable_prev)) begin
          if (rep_cnt == REP_LAST) begin
            valid_d = 1'b1;
          end else begin
            rep_d = rep_cnt + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx     <= '0;
      valid   <= 1'b0;
      multi   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      valid   <= valid_d;
      multi   <= multi_d;
    end
  end

`ifdef BUTTON_ENCODER_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_prev <= '0;
      rep_cnt     <= '0;
    end else begin
      stable_prev <= stable;
      rep_cnt     <= rep_d;
    end
  end
`endif

  assign held = (state_q == HELD);

endmodule
